// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch
// (IF) and the MEM-stage data port, one outstanding transaction at a time.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   if_req/if_addr  fetch read request; if_flush drops a pending fetch
//   if_gnt          fetch command accepted (combinational)
//   if_rvalid/data  fetch response, one-cycle registered pulse
//   dm_req/we/addr/wdata/be  data request
//   dm_gnt          data command accepted (combinational)
//   dm_rvalid/data  data response or write ack (rdata 0 for writes)
//   mem_req/we/addr/wdata/be  registered command to memory
//   mem_gnt         memory accepted the command
//   mem_rvalid/data memory response
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [1:0] state;
  logic       owner_if;
  logic       drop;
  logic [3:0] starve_cnt;

  logic idle;
  logic if_cand;
  logic fetch_pri;

  always_comb begin
    idle      = (state == IDLE);
    if_cand   = if_req && !if_flush;
    fetch_pri = (starve_cnt == SMAX);
    if_gnt    = idle && if_cand && (!dm_req || fetch_pri);
    dm_gnt    = idle && dm_req && !if_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            owner_if   <= 1'b1;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (dm_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            owner_if  <= 1'b0;
            state     <= ISSUE;
            // Count only grants that made a live fetch wait.
            if (!if_req)
              starve_cnt <= '0;
            else if (!fetch_pri)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE: begin
          if (owner_if && if_flush)
            drop <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (owner_if && if_flush)
            drop <= 1'b1;
          if (mem_rvalid) begin
            // A flush arriving with the response still kills it.
            if (owner_if) begin
              if (!(drop || if_flush)) begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
              end
            end else begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_we ? '0 : mem_rdata;
            end
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand sequences and a randomized
// run against a transaction-level reference model of mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk1(input string nm, input logic act, input logic ev);
    checks++;
    if (act !== ev) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, ev, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] ev);
    checks++;
    if (act !== ev) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, ev, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic        r, ifr, ifl;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da;
    logic        mg, mrv;
    logic [31:0] mrd;
    logic        eig, edg, emr;
    logic [31:0] ema;
    logic        eirv, edrv;
    logic [31:0] erd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, ifr, ifl, input logic [31:0] ia,
    input logic dr, dw, input logic [31:0] da,
    input logic mg, mrv, input logic [31:0] mrd,
    input logic eig, edg, emr, input logic [31:0] ema,
    input logic eirv, edrv, input logic [31:0] erd);
    vec_t v;
    v.r = r; v.ifr = ifr; v.ifl = ifl; v.ia = ia;
    v.dr = dr; v.dw = dw; v.da = da;
    v.mg = mg; v.mrv = mrv; v.mrd = mrd;
    v.eig = eig; v.edg = edg; v.emr = emr; v.ema = ema;
    v.eirv = eirv; v.edrv = edrv; v.erd = erd;
    return v;
  endfunction

  // reference model state
  bit          m_busy, m_acc, m_own_if, m_drop;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_streak;
  bit          p_if_rv, p_dm_rv;
  logic [31:0] p_if_rd, p_dm_rd;

  int          order[$];

  initial begin
    rst = 0;
    idle_inputs();
    do_reset();

    @(negedge clk);
    chk1("rst_if_gnt", if_gnt, 0);
    chk1("rst_dm_gnt", dm_gnt, 0);
    chk1("rst_mem_req", mem_req, 0);
    chk1("rst_mem_we", mem_we, 0);
    chk32("rst_mem_addr", mem_addr, 0);
    chk32("rst_mem_wdata", mem_wdata, 0);
    chk32("rst_mem_be", {28'd0, mem_be}, 0);
    chk1("rst_if_rvalid", if_rvalid, 0);
    chk1("rst_dm_rvalid", dm_rvalid, 0);
    chk32("rst_if_rdata", if_rdata, 0);
    chk32("rst_dm_rdata", dm_rdata, 0);
    step();

    // single fetch
    tv.push_back(mk(0,1,0,32'h0, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,1,32'h00500093,
                    0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,0,0, 0,0,0,0,
                    1,0,32'h00500093));
    // contention: data first, fetch on the dm_rvalid cycle
    tv.push_back(mk(0,1,0,32'h4, 1,0,32'h100, 0,0,0, 0,1,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h4, 0,0,0, 1,0,0, 0,0,1,32'h100, 0,0,0));
    tv.push_back(mk(0,1,0,32'h4, 0,0,0, 0,1,32'h11111111,
                    0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h4, 0,0,0, 0,0,0, 1,0,0,0,
                    0,1,32'h11111111));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,32'h4, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,1,32'h22, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h22));
    // flush during WAIT drops the response
    tv.push_back(mk(0,1,0,32'h8, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,32'h8, 0,0,0));
    tv.push_back(mk(0,0,1,32'h0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,1,32'h33, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'hC, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,32'hC, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,1,32'h44, 0,0,0,0, 0,0,0));
    // flush on the pulse cycle does not affect it
    tv.push_back(mk(0,0,1,32'h0, 0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h44));
    // flush with if_req in IDLE blocks the grant
    tv.push_back(mk(0,1,1,32'h10, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h10, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,32'h10, 0,0,0));
    // reset in WAIT together with the memory response
    tv.push_back(mk(1,0,0,32'h0, 0,0,0, 0,1,32'h55, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h14, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 1,0,0, 0,0,1,32'h14, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,1,32'h66, 0,0,0,0, 0,0,0));
    tv.push_back(mk(0,0,0,32'h0, 0,0,0, 0,0,0, 0,0,0,0, 1,0,32'h66));

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].r;
      if_req = tv[i].ifr; if_flush = tv[i].ifl; if_addr = tv[i].ia;
      dm_req = tv[i].dr; dm_we = tv[i].dw; dm_addr = tv[i].da;
      dm_wdata = 0; dm_be = 4'hF;
      mem_gnt = tv[i].mg; mem_rvalid = tv[i].mrv; mem_rdata = tv[i].mrd;
      @(negedge clk);
      chk1($sformatf("v%0d_if_gnt", i), if_gnt, tv[i].eig);
      chk1($sformatf("v%0d_dm_gnt", i), dm_gnt, tv[i].edg);
      chk1($sformatf("v%0d_mem_req", i), mem_req, tv[i].emr);
      if (tv[i].emr)
        chk32($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ema);
      chk1($sformatf("v%0d_if_rvalid", i), if_rvalid, tv[i].eirv);
      chk1($sformatf("v%0d_dm_rvalid", i), dm_rvalid, tv[i].edrv);
      if (tv[i].eirv)
        chk32($sformatf("v%0d_if_rdata", i), if_rdata, tv[i].erd);
      if (tv[i].edrv)
        chk32($sformatf("v%0d_dm_rdata", i), dm_rdata, tv[i].erd);
      step();
    end
    idle_inputs();

    // starvation guard: both held, memory always ready
    dm_req = 1; dm_addr = 32'h200; dm_be = 4'hF;
    if_req = 1; if_addr = 32'h300;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if_gnt && dm_gnt) begin
        errors++;
        $display("FAIL starve_both_gnt cycle=%0d", c);
      end
      if (dm_gnt) order.push_back(0);
      if (if_gnt) order.push_back(1);
      step();
    end
    if_req = 0; dm_req = 0;
    chk32("starve_count", order.size(), 10);
    for (int k = 0; k < order.size(); k++)
      chk32($sformatf("starve_order%0d", k), order[k],
            (k % 5 == 4) ? 1 : 0);
    repeat (4) step();
    idle_inputs();
    step();

    // write held off by memory for 3 cycles
    dm_req = 1; dm_we = 1; dm_addr = 32'h10;
    dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    @(negedge clk);
    chk1("wr_dm_gnt", dm_gnt, 1);
    step();
    dm_req = 0; dm_addr = 32'hFFFF; dm_wdata = 0; dm_be = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk1($sformatf("wr_stall%0d_req", s), mem_req, 1);
      chk1($sformatf("wr_stall%0d_we", s), mem_we, 1);
      chk32($sformatf("wr_stall%0d_addr", s), mem_addr, 32'h10);
      chk32($sformatf("wr_stall%0d_wdata", s), mem_wdata, 32'hDEADBEEF);
      chk32($sformatf("wr_stall%0d_be", s), {28'd0, mem_be}, 32'h3);
      step();
    end
    mem_gnt = 1;
    @(negedge clk);
    chk1("wr_req_at_gnt", mem_req, 1);
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk1("wr_req_wait", mem_req, 0);
    chk1("wr_no_early_rv", dm_rvalid, 0);
    step();
    mem_rvalid = 0;
    @(negedge clk);
    chk1("wr_dm_rvalid", dm_rvalid, 1);
    chk32("wr_dm_rdata", dm_rdata, 0);
    step();
    @(negedge clk);
    chk1("wr_rvalid_pulse", dm_rvalid, 0);
    step();

    // randomized run against the reference model
    do_reset();
    m_busy = 0; m_acc = 0; m_own_if = 0; m_drop = 0; m_streak = 0;
    p_if_rv = 0; p_dm_rv = 0;
    for (int c = 0; c < 3000; c++) begin
      bit eg_if, eg_dm, n_if_rv, n_dm_rv;
      if (!if_req || if_gnt === 1'bx || c == 0 || !(p_if_rv === 1'bx)) ;
      @(negedge clk);
      eg_if = !m_busy && if_req && !if_flush &&
              (!dm_req || m_streak == 4);
      eg_dm = !m_busy && dm_req && !eg_if;
      chk1("rnd_if_gnt", if_gnt, eg_if);
      chk1("rnd_dm_gnt", dm_gnt, eg_dm);
      chk1("rnd_mem_req", mem_req, m_busy && !m_acc);
      if (m_busy && !m_acc) begin
        chk1("rnd_mem_we", mem_we, m_we);
        chk32("rnd_mem_addr", mem_addr, m_addr);
        chk32("rnd_mem_wdata", mem_wdata, m_wdata);
        chk32("rnd_mem_be", {28'd0, mem_be}, {28'd0, m_be});
      end
      chk1("rnd_if_rvalid", if_rvalid, p_if_rv);
      chk1("rnd_dm_rvalid", dm_rvalid, p_dm_rv);
      if (p_if_rv) chk32("rnd_if_rdata", if_rdata, p_if_rd);
      if (p_dm_rv) chk32("rnd_dm_rdata", dm_rdata, p_dm_rd);

      n_if_rv = 0; n_dm_rv = 0;
      if (m_busy) begin
        if (if_flush && m_own_if) m_drop = 1;
        if (!m_acc) begin
          if (mem_gnt) m_acc = 1;
        end else if (mem_rvalid) begin
          if (m_own_if) begin
            n_if_rv = !m_drop;
            if (!m_drop) p_if_rd = mem_rdata;
          end else begin
            n_dm_rv = 1;
            p_dm_rd = m_we ? 32'h0 : mem_rdata;
          end
          m_busy = 0; m_drop = 0;
        end
      end else if (eg_if) begin
        m_busy = 1; m_acc = 0; m_own_if = 1;
        m_we = 0; m_addr = if_addr; m_wdata = 0; m_be = 4'hF;
        m_streak = 0;
      end else if (eg_dm) begin
        m_busy = 1; m_acc = 0; m_own_if = 0;
        m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
        m_streak = if_req ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
      end
      p_if_rv = n_if_rv; p_dm_rv = n_dm_rv;

      step();
      // requesters hold until granted, then may change
      if (!if_req || eg_if) begin
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = $urandom & 32'hFFFC;
      end
      if (!dm_req || eg_dm) begin
        dm_req = ($urandom_range(0, 1) == 1);
        dm_we = ($urandom_range(0, 1) == 1);
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = 4'($urandom_range(0, 15));
      end
      if_flush = ($urandom_range(0, 7) == 0);
      mem_gnt = ($urandom_range(0, 1) == 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
